// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the arbiter state encoding, the memory write-enable codes and the access-size codes.
package dm_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } state_t;

    localparam logic [1:0] WEN_WRITE = 2'b01;
    localparam logic [1:0] WEN_IDLE  = 2'b00;

    localparam logic [1:0] BEXT_LBU = 2'b00;
    localparam logic [1:0] BEXT_LB  = 2'b01;
    localparam logic [1:0] BEXT_SB  = 2'b10;
    localparam logic [1:0] BEXT_W   = 2'b11;

endpackage

// File: rtl/dm_rr_pick.sv
// Two-input round-robin picker: returns a one-hot grant, and breaks ties against the last winner.
// Purely combinational with zero latency; it holds no state and applies no backpressure of its own.
module dm_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter: round-robin between ports, with an optional port-1 lock that a waiting port 0 can break.
// Grants are combinational, read data returns 1 cycle after the grant, and a port without a grant simply holds its req.
module dm_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic [11:0] p0_addr,
    input  logic [11:0] p1_addr,
    input  logic [31:0] p0_din,
    input  logic [31:0] p1_din,
    input  logic [1:0]  p0_byteExt,
    input  logic [1:0]  p1_byteExt,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic        p1_lock,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_byteExt,
    output logic [1:0]  mem_wEn,
    input  logic [31:0] mem_dout,
    output logic        lock_broken
);
    import dm_arb_pkg::*;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic       last_q;
    logic [7:0] wait_q;
    logic [1:0] rr_gnt;
    logic       force_break;
    logic       p0_rv_q, p1_rv_q;

    dm_rr_pick u_pick (
        .req  ({p1_req, p0_req}),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    assign force_break = (state_q == LOCK1) && (wait_q == MAX_WAIT_C);
    assign lock_broken = force_break && !rst;

    // Gating by rst drops a read response that is already in flight when reset arrives.
    assign p0_rvalid = p0_rv_q && !rst;
    assign p1_rvalid = p1_rv_q && !rst;

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) begin
                p0_gnt = rr_gnt[0];
                p1_gnt = rr_gnt[1];
            end else begin
                p1_gnt = p1_req;
            end
        end
    end

    always_comb begin
        mem_addr    = '0;
        mem_din     = '0;
        mem_byteExt = 2'b00;
        mem_wEn     = WEN_IDLE;
        if (p0_gnt) begin
            mem_addr    = p0_addr;
            mem_din     = p0_din;
            mem_byteExt = p0_byteExt;
            mem_wEn     = p0_we ? WEN_WRITE : WEN_IDLE;
        end else if (p1_gnt) begin
            mem_addr    = p1_addr;
            mem_din     = p1_din;
            mem_byteExt = p1_byteExt;
            mem_wEn     = p1_we ? WEN_WRITE : WEN_IDLE;
        end
    end

    // A forced release wins over port 1 trying to extend its lock in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (p1_gnt && p1_lock) state_d = LOCK1;
            end
            LOCK1: begin
                if (force_break)                state_d = IDLE;
                else if (p1_gnt && !p1_lock)    state_d = IDLE;
                else if (!p1_req && !p1_lock)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            wait_q   <= 8'd0;
            p0_rv_q  <= 1'b0;
            p1_rv_q  <= 1'b0;
            p0_rdata <= 32'd0;
            p1_rdata <= 32'd0;
        end else begin
            state_q <= state_d;
            if (force_break || p1_gnt) last_q <= 1'b1;
            else if (p0_gnt)           last_q <= 1'b0;
            if (state_q == LOCK1 && p0_req && !force_break) wait_q <= wait_q + 8'd1;
            else                                            wait_q <= 8'd0;
            p0_rv_q <= p0_gnt && !p0_we;
            p1_rv_q <= p1_gnt && !p1_we;
            if (p0_gnt && !p0_we) p0_rdata <= mem_dout;
            if (p1_gnt && !p1_we) p1_rdata <= mem_dout;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomised and directed bench for dm_arbiter, checked against a rule-level reference model.
// Read responses go into a scoreboard; a separate monitor compares them whenever the DUT presents rvalid.
module tb_dm_arbiter;

    localparam int MW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p1_req, p0_we, p1_we, p1_lock;
    logic [11:0] p0_addr, p1_addr;
    logic [31:0] p0_din, p1_din;
    logic [1:0]  p0_byteExt, p1_byteExt;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, lock_broken;
    logic [31:0] p0_rdata, p1_rdata, mem_din, mem_dout;
    logic [11:0] mem_addr;
    logic [1:0]  mem_byteExt, mem_wEn;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } rd_t;
    rd_t q0[$];
    rd_t q1[$];

    bit m_lock;
    int m_last;
    int m_wait;

    always #5 clk = ~clk;

    function automatic logic [31:0] dout_f(logic [11:0] a, int c);
        return {a, c[7:0], a} ^ 32'h3C00_00C3;
    endfunction

    assign mem_dout = dout_f(mem_addr, cyc);

    dm_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p1_req(p1_req),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_din(p0_din), .p1_din(p1_din),
        .p0_byteExt(p0_byteExt), .p1_byteExt(p1_byteExt),
        .p0_we(p0_we), .p1_we(p1_we), .p1_lock(p1_lock),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_byteExt(mem_byteExt),
        .mem_wEn(mem_wEn), .mem_dout(mem_dout), .lock_broken(lock_broken)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Compares one cycle against the reference model, then advances the model and the clock.
    task automatic step();
        int w;
        bit brk;
        int nw;
        logic [11:0] ea;
        logic [31:0] ed;
        logic [1:0]  eb, ewe;
        @(negedge clk);
        if (rst)          w = -1;
        else if (!m_lock) begin
            if (p0_req && p1_req) w = (m_last == 0) ? 1 : 0;
            else if (p0_req)      w = 0;
            else if (p1_req)      w = 1;
            else                  w = -1;
        end else          w = p1_req ? 1 : -1;
        brk = !rst && m_lock && (m_wait == MW);
        ea = 12'd0; ed = 32'd0; eb = 2'b00; ewe = 2'b00;
        if (w == 0) begin
            ea = p0_addr; ed = p0_din; eb = p0_byteExt; ewe = p0_we ? 2'b01 : 2'b00;
        end else if (w == 1) begin
            ea = p1_addr; ed = p1_din; eb = p1_byteExt; ewe = p1_we ? 2'b01 : 2'b00;
        end
        chk("p0_gnt", 32'(p0_gnt), 32'(w == 0));
        chk("p1_gnt", 32'(p1_gnt), 32'(w == 1));
        chk("lock_broken", 32'(lock_broken), 32'(brk));
        chk("mem_wEn", 32'(mem_wEn), 32'(ewe));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_din", mem_din, ed);
        chk("mem_byteExt", 32'(mem_byteExt), 32'(eb));
        if (w == 0 && !p0_we) q0.push_back('{cyc + 1, dout_f(p0_addr, cyc)});
        if (w == 1 && !p1_we) q1.push_back('{cyc + 1, dout_f(p1_addr, cyc)});
        if (rst) begin
            m_lock = 1'b0; m_last = 1; m_wait = 0;
        end else begin
            nw = (m_lock && p0_req && !brk) ? m_wait + 1 : 0;
            if (w >= 0) m_last = w;
            if (brk)    m_last = 1;
            if (!m_lock)                 m_lock = (w == 1) && p1_lock;
            else if (brk)                m_lock = 1'b0;
            else if (w == 1)             m_lock = p1_lock;
            else if (!p1_req && !p1_lock) m_lock = 1'b0;
            m_wait = nw;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin : monitor
        bit e0, e1;
        forever begin
            @(negedge clk);
            e0 = (q0.size() > 0) && (q0[0].due == cyc);
            e1 = (q1.size() > 0) && (q1[0].due == cyc);
            chk("p0_rvalid", 32'(p0_rvalid), 32'(e0 && !rst));
            chk("p1_rvalid", 32'(p1_rvalid), 32'(e1 && !rst));
            if (e0 && !rst) chk("p0_rdata", p0_rdata, q0[0].dat);
            if (e1 && !rst) chk("p1_rdata", p1_rdata, q1[0].dat);
            if (e0) void'(q0.pop_front());
            if (e1) void'(q1.pop_front());
        end
    end

    initial begin : stim
        rst = 1'b1;
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0; p1_lock = 0;
        p0_addr = 0; p1_addr = 0; p0_din = 0; p1_din = 0; p0_byteExt = 0; p1_byteExt = 0;
        m_lock = 1'b0; m_last = 1; m_wait = 0;
        steps(2);
        chk("reset p0_rdata", p0_rdata, 32'd0);
        chk("reset p1_rdata", p1_rdata, 32'd0);
        rst = 1'b0;
        steps(3);

        // Simultaneous reads: port 0 first, then port 1.
        p0_req = 1; p0_addr = 12'h010; p1_req = 1; p1_addr = 12'h020;
        step();
        p0_req = 0;
        step();
        p1_req = 0;
        steps(2);

        // Port 1 word write.
        p1_req = 1; p1_we = 1; p1_byteExt = 2'b11; p1_addr = 12'h004; p1_din = 32'hDEADBEEF;
        step();
        p1_req = 0; p1_we = 0;
        steps(2);

        // Four-beat locked burst, with port 0 waiting throughout.
        p0_req = 1; p0_we = 1; p0_addr = 12'h100; p0_din = 32'h1234_5678;
        step();
        p1_req = 1; p1_lock = 1; p1_addr = 12'h200;
        steps(3);
        p1_lock = 0;
        step();
        p1_req = 0;
        step();
        p0_req = 0;
        steps(2);

        // Port 1 holds the lock indefinitely, so port 0 forces it open.
        p0_req = 1;
        step();
        p1_req = 1; p1_lock = 1; p0_we = 0;
        steps(14);
        p1_req = 0; p1_lock = 0; p0_req = 0;
        steps(3);

        // Reset arrives while a port-0 read response is pending.
        p0_req = 1; p0_addr = 12'h0AA;
        step();
        p0_req = 0; rst = 1;
        step();
        rst = 0; p0_req = 1; p1_req = 1;
        step();
        p0_req = 0; p1_req = 0;
        steps(2);

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            p0_req     = ($urandom_range(0, 3) != 0);
            p1_req     = ($urandom_range(0, 3) != 0);
            p1_lock    = ($urandom_range(0, 2) != 0);
            p0_we      = $urandom_range(0, 1) == 1;
            p1_we      = $urandom_range(0, 1) == 1;
            p0_addr    = 12'($urandom);
            p1_addr    = 12'($urandom);
            p0_din     = $urandom;
            p1_din     = $urandom;
            p0_byteExt = 2'($urandom);
            p1_byteExt = 2'($urandom);
            step();
        end
        rst = 0; p0_req = 0; p1_req = 0; p1_lock = 0;
        steps(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8: cycles port 0 may wait during a port-1 lock before the lock is broken (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 p0_req, p1_req  input  1 each  transfer request from port 0 (CPU data) and port 1 (DMA/loader).
REQ-005 p0_addr, p1_addr  input  12  byte address.
REQ-006 p0_din, p1_din  input  32  write data.
REQ-007 p0_byteExt, p1_byteExt  input  2 each  access size/extension code: 00 byte zero-extend, 01 byte sign-extend, 10 byte store, 11 word.
REQ-008 p0_we, p1_we  input  1 each  1 = write, 0 = read.
REQ-009 p1_lock  input  1  port 1 requests exclusive ownership after its current transfer.
REQ-010 p0_gnt, p1_gnt  output  1 each  transfer accepted this cycle (combinational).
REQ-011 p0_rdata, p1_rdata  output  32 each  registered read data.
REQ-012 p0_rvalid, p1_rvalid  output  1 each  one-cycle pulse: rdata valid.
REQ-013 mem_addr  output  12; mem_din  output  32; mem_byteExt  output  2; mem_wEn  output  2 -- drive the data memory.
REQ-014 mem_dout  input  32  combinational read data from the data memory.
REQ-015 lock_broken  output  1  one-cycle pulse when a lock is forcibly released.

Function
REQ-016 A transfer on port N is accepted in the cycle in which pN_req and pN_gnt are both high; at most one gnt is high per cycle.
REQ-017 States: IDLE (round-robin) and LOCK1 (port 1 owns the memory).
REQ-018 IDLE, single requester: that port is granted.
REQ-019 IDLE, both requesting: the port other than the last-granted port is granted; the last-granted pointer updates on every accepted transfer.
REQ-020 Granted port's addr, din and byteExt drive mem_*; mem_wEn = 01 if the granted port's we = 1, else 00.
REQ-021 With no grant, mem_wEn = 00 and mem_addr/mem_din/mem_byteExt = 0.
REQ-022 Accepted read: mem_dout is captured into pN_rdata at that edge; pN_rvalid is high the following cycle only, giving a fixed read latency of 1 cycle.
REQ-023 Accepted write: no rvalid; the memory commits it at the same edge.
REQ-024 IDLE -> LOCK1 when a port-1 transfer is accepted with p1_lock = 1.
REQ-025 In LOCK1 only port 1 may be granted; p0_gnt = 0.
REQ-026 LOCK1 -> IDLE when a port-1 transfer is accepted with p1_lock = 0, or when p1_req = 0 and p1_lock = 0.
REQ-027 Wait counter (8 bit): in LOCK1, increments each cycle p0_req = 1; clears in IDLE and whenever p0_req = 0.
REQ-028 When the wait counter equals MAX_WAIT: lock_broken pulses, the state goes to IDLE, the last-granted pointer is set to port 1, and port 0 wins the next cycle.
REQ-029 A forced release takes priority over a simultaneous port-1 accepted transfer with p1_lock = 1; that transfer completes, but the state does not remain LOCK1.
REQ-030 Within 2*MAX_WAIT+2 cycles, a requester holding req continuously is always granted.

Reset
REQ-031 On rst: state IDLE, last-granted pointer = port 1 (port 0 wins the first tie), wait counter 0, p0/p1_rvalid 0, p0/p1_rdata 0, lock_broken 0.
REQ-032 While rst is high, both gnt outputs are 0 and mem_wEn = 00.
REQ-033 rst asserted mid-lock or with a read outstanding: the lock is dropped and the pending rvalid is suppressed.

Structure
REQ-034 Shared package dm_arb_pkg holds:
- state enum {IDLE, LOCK1}
- constants WEN_WRITE = 2'b01 and WEN_IDLE = 2'b00
- byteExt codes BEXT_LBU = 00, BEXT_LB = 01, BEXT_SB = 10, BEXT_W = 11
REQ-035 One sub-module, dm_rr_pick: two-input round-robin picker (reqs, last pointer -> one-hot grant).

Verification
REQ-036 After reset, both ports read simultaneously with p0_addr = 0x010 and p1_addr = 0x020 -> p0_gnt in cycle 1, p1_gnt in cycle 2; each rvalid one cycle after its own gnt, with rdata = the mem_dout value.
REQ-037 Port 1 word write (we = 1, byteExt = 11, addr 0x004, din 0xDEADBEEF) -> mem_wEn = 01 and mem_addr = 0x004 in the gnt cycle; no rvalid.
REQ-038 Port 1 four-beat burst with p1_lock = 1 on beats 1-3 and 0 on beat 4, with p0_req high throughout and MAX_WAIT = 8 -> p0_gnt stays 0 during the burst, then is granted the cycle after beat 4.
REQ-039 Port 1 holds lock indefinitely, p0_req high, MAX_WAIT = 3 -> lock_broken pulses after 3 waiting cycles; p0_gnt the next cycle; p1 and p0 then alternate.
REQ-040 rst pulsed in the cycle after an accepted p0 read -> p0_rvalid stays 0, state IDLE, and the first tie goes to port 0.
REQ-041 No requests -> mem_wEn = 00 and both gnt = 0 every cycle.
